// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned STREAK_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } resp_owner_t;

endpackage : mem_arb_pkg

// File: rtl/arb_perf_counters.sv
// Wrapping event counters for arbiter contention and per-port wait cycles.
module arb_perf_counters
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        conflict_i,
  input  logic        if_wait_i,
  input  logic        d_wait_i,
  output logic [31:0] perf_conflicts_o,
  output logic [31:0] perf_if_wait_o,
  output logic [31:0] perf_d_wait_o
);

  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] conflicts_q, conflicts_d;
  logic [CNT_W-1:0] if_wait_q, if_wait_d;
  logic [CNT_W-1:0] d_wait_q, d_wait_d;

  always_comb begin
    conflicts_d = conflicts_q;
    if_wait_d   = if_wait_q;
    d_wait_d    = d_wait_q;
    if (conflict_i) conflicts_d = conflicts_q + CNT_W'(1);
    if (if_wait_i)  if_wait_d   = if_wait_q + CNT_W'(1);
    if (d_wait_i)   d_wait_d    = d_wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflicts_q <= '0;
      if_wait_q   <= '0;
      d_wait_q    <= '0;
    end else begin
      conflicts_q <= conflicts_d;
      if_wait_q   <= if_wait_d;
      d_wait_q    <= d_wait_d;
    end
  end

  assign perf_conflicts_o = conflicts_q;
  assign perf_if_wait_o   = if_wait_q;
  assign perf_d_wait_o    = d_wait_q;

endmodule : arb_perf_counters

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-port SRAM and routes read responses.
// Define ARB_PERF_CNT_EN to add the perf_* contention/wait counters.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MASK_W       = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_mask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  resp_owner_t         owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                contested_c;
  logic                fetch_turn_c;

  assign contested_c  = if_req & d_req;
  assign fetch_turn_c = (streak_q == STREAK_W'(STARVE_LIMIT));

  // Data normally wins a tie; fetch wins once data has starved it long enough.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if_gnt = if_req & (~d_req | fetch_turn_c);
      d_gnt  = d_req & (~if_req | ~fetch_turn_c);
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_mask  = d_mask;
    end
  end

  // Next owner of the memory read response and next starvation streak.
  always_comb begin
    owner_d  = OWN_NONE;
    streak_d = streak_q;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_D;
    end
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (contested_c && d_gnt && !fetch_turn_c) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Response is dropped while reset is asserted so no stale data escapes.
  assign if_rvalid = rst_n & (owner_q == OWN_IF);
  assign d_rvalid  = rst_n & (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  arb_perf_counters u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .conflict_i       (contested_c),
    .if_wait_i        (if_req & ~if_gnt),
    .d_wait_i         (d_req & ~d_gnt),
    .perf_conflicts_o (perf_conflicts),
    .perf_if_wait_o   (perf_if_wait),
    .perf_d_wait_o    (perf_d_wait)
  );
`endif

endmodule : unified_mem_arbiter
